// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - opcodes, accumulator select codes, FSM states and strobe bundle
package cpu_sequencer_pkg;

  localparam logic [3:0] OP_NOP        = 4'b0000;
  localparam logic [3:0] OP_ADD        = 4'b0001;
  localparam logic [3:0] OP_SUB        = 4'b0010;
  localparam logic [3:0] OP_NOR        = 4'b0011;
  localparam logic [3:0] OP_REG_TO_ACC = 4'b0100;
  localparam logic [3:0] OP_ACC_TO_REG = 4'b0101;
  localparam logic [3:0] OP_JMPZ_REG   = 4'b0110;
  localparam logic [3:0] OP_JMPZ_IMM   = 4'b0111;
  localparam logic [3:0] OP_JMPC_REG   = 4'b1000;
  localparam logic [3:0] OP_JMPC_IMM   = 4'b1010;
  localparam logic [3:0] OP_SHFL       = 4'b1011;
  localparam logic [3:0] OP_SHFR       = 4'b1100;
  localparam logic [3:0] OP_IMM_TO_ACC = 4'b1101;
  localparam logic [3:0] OP_HALT       = 4'b1111;

  localparam logic [1:0] SEL_ACC_HOLD = 2'b00;
  localparam logic [1:0] SEL_ACC_REG  = 2'b01;
  localparam logic [1:0] SEL_ACC_IMM  = 2'b10;
  localparam logic [1:0] SEL_ACC_ALU  = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_ALU_WAIT,
    ST_EXEC,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic       inc_pc;
    logic       sel_pc;
    logic       load_pc;
    logic       load_reg;
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
  } strobes_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOR) ||
           (op == OP_SHFL) || (op == OP_SHFR);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction memory handshake and datapath strobe bundle
interface cpu_sequencer_if;

  logic       IMemReq;
  logic       IMemAck;
  logic       LoadIR;
  logic       IncPC;
  logic       SelPC;
  logic       LoadPC;
  logic       LoadReg;
  logic       LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;

  modport master (
    output IMemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
    input  IMemAck
  );

  modport slave (
    input  IMemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
    output IMemAck
  );

endinterface

// File: rtl/cpu_sequencer_exec_decode.sv
// rtl/cpu_sequencer_exec_decode.sv - EXEC-cycle strobe decode from opcode and flags
module cpu_sequencer_exec_decode
  import cpu_sequencer_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_z,
  input  logic       i_c,
  output strobes_t   o_strobes,
  output logic       o_illegal_op
);

  always_comb begin
    o_strobes    = '0;
    o_illegal_op = 1'b0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_NOR, OP_SHFL, OP_SHFR: begin
        o_strobes.load_acc = 1'b1;
        o_strobes.sel_acc  = SEL_ACC_ALU;
        o_strobes.sel_alu  = i_opcode;
        o_strobes.inc_pc   = 1'b1;
      end
      OP_REG_TO_ACC: begin
        o_strobes.load_acc = 1'b1;
        o_strobes.sel_acc  = SEL_ACC_REG;
        o_strobes.inc_pc   = 1'b1;
      end
      OP_IMM_TO_ACC: begin
        o_strobes.load_acc = 1'b1;
        o_strobes.sel_acc  = SEL_ACC_IMM;
        o_strobes.inc_pc   = 1'b1;
      end
      OP_ACC_TO_REG: begin
        o_strobes.load_reg = 1'b1;
        o_strobes.inc_pc   = 1'b1;
      end
      OP_JMPZ_REG, OP_JMPZ_IMM: begin
        o_strobes.load_pc = i_z;
        o_strobes.sel_pc  = i_z & (i_opcode == OP_JMPZ_REG);
        o_strobes.inc_pc  = ~i_z;
      end
      OP_JMPC_REG, OP_JMPC_IMM: begin
        o_strobes.load_pc = i_c;
        o_strobes.sel_pc  = i_c & (i_opcode == OP_JMPC_REG);
        o_strobes.inc_pc  = ~i_c;
      end
      // HALT never reaches EXEC; listed so it is not flagged illegal
      OP_NOP, OP_HALT: begin
        o_strobes.inc_pc = 1'b1;
      end
      default: begin
        o_strobes.inc_pc = 1'b1;
        o_illegal_op     = 1'b1;
      end
    endcase
    if (!o_strobes.load_acc) o_strobes.sel_acc = SEL_ACC_HOLD;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - FETCH/DECODE/ALU_WAIT/EXEC/HALTED sequencer for the accumulator CPU
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int ALU_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       Opcode,
  input  logic             Z,
  input  logic             C,
  cpu_sequencer_if.master  bus,
  output logic             Halted,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [3:0]       LAT_LOAD = (ALU_LAT > 0) ? 4'(ALU_LAT - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_next_state;
  logic [3:0]       r_wait_cnt, w_next_wait_cnt;
  logic [CNT_W-1:0] r_instr_count;
  strobes_t         w_exec_strobes, w_strobes;
  logic             w_exec_illegal, w_illegal;
  logic             w_imem_req, w_load_ir, w_halted;

  cpu_sequencer_exec_decode u_exec_decode (
    .i_opcode     (Opcode),
    .i_z          (Z),
    .i_c          (C),
    .o_strobes    (w_exec_strobes),
    .o_illegal_op (w_exec_illegal)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= ST_FETCH;
      r_wait_cnt    <= 4'd0;
      r_instr_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      if (r_state == ST_EXEC) r_instr_count <= r_instr_count + CNT_ONE;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_strobes       = '0;
    w_imem_req      = 1'b0;
    w_load_ir       = 1'b0;
    w_halted        = 1'b0;
    w_illegal       = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.IMemAck) begin
          w_load_ir    = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (Opcode == OP_HALT) begin
          w_next_state = ST_HALTED;
        end else if ((ALU_LAT > 0) && is_alu_op(Opcode)) begin
          w_next_state    = ST_ALU_WAIT;
          w_next_wait_cnt = LAT_LOAD;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_ALU_WAIT: begin
        w_strobes.sel_alu = Opcode;
        if (r_wait_cnt == 4'd0) w_next_state = ST_EXEC;
        else                    w_next_wait_cnt = r_wait_cnt - 4'd1;
      end
      ST_EXEC: begin
        w_strobes    = w_exec_strobes;
        w_illegal    = w_exec_illegal;
        w_next_state = ST_FETCH;
      end
      ST_HALTED: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // Reset masks every output so an aborted instruction leaves no strobe behind
  assign bus.IMemReq = w_imem_req         & ~Rst;
  assign bus.LoadIR  = w_load_ir          & ~Rst;
  assign bus.IncPC   = w_strobes.inc_pc   & ~Rst;
  assign bus.SelPC   = w_strobes.sel_pc   & ~Rst;
  assign bus.LoadPC  = w_strobes.load_pc  & ~Rst;
  assign bus.LoadReg = w_strobes.load_reg & ~Rst;
  assign bus.LoadAcc = w_strobes.load_acc & ~Rst;
  assign bus.SelAcc  = w_strobes.sel_acc  & {2{~Rst}};
  assign bus.SelALU  = w_strobes.sel_alu  & {4{~Rst}};
  assign Halted      = w_halted  & ~Rst;
  assign IllegalOp   = w_illegal & ~Rst;
  assign InstrCount  = Rst ? '0 : r_instr_count;

endmodule
